fetch_sequencer: RTL and testbench

//  Instruction-fetch controller of the model computer; drives the PC's increment input.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 13 +
 rtl/fetch_sequencer_wait_timer.sv | 28 ++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int         FETCH_AW      = 4;
    localparam int         FETCH_DW      = 8;
    localparam int         FETCH_TIMEOUT = 15;
    localparam int         OP_W          = 4;
    localparam logic [3:0] FETCH_HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_INC  = 3'd3,
        S_EXEC = 3'd4,
        S_HALT = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Program-memory read port: sequencer is the master, memory the slave.
interface fetch_sequencer_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;

    modport master (output mem_rd, output mem_addr, input mem_data, input mem_ready);
    modport slave  (input mem_rd, input mem_addr, output mem_data, output mem_ready);
endinterface

// File: rtl/fetch_sequencer_wait_timer.sv
// Read-wait counter: synchronous clear, count enable, saturating, terminal-count flag.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic CLRn,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT    = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads program memory at pc_q, loads IR, pulses IPC,
// and holds IR until the execution unit reports done.
//   state  | meaning
//   S_IDLE | waiting for run
//   S_ADDR | latch pc_q as address, start read
//   S_WAIT | read outstanding, timeout running
//   S_INC  | IR loaded; IPC high unless HALT opcode
//   S_EXEC | IR held until ex_done
//   S_HALT | stopped; only CLRn leaves
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              AW      = FETCH_AW,
    parameter int              DW      = FETCH_DW,
    parameter logic [OP_W-1:0] HALT_OP = FETCH_HALT_OP,
    parameter int              TIMEOUT = FETCH_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 CLRn,
    input  logic                 run,
    input  logic [AW-1:0]        pc_q,
    output logic                 IPC,
    fetch_sequencer_if.master    mem,
    output logic [DW-1:0]        ir_q,
    output logic                 ir_valid,
    input  logic                 ex_done,
    output logic                 halted,
    output logic                 bus_err
);
    state_t state;
    logic   wait_clr;
    logic   wait_en;
    logic   wait_tc;
    logic   op_halt;

    assign op_halt  = (ir_q[DW-1 -: OP_W] == HALT_OP);
    assign wait_clr = (state == S_ADDR);
    assign wait_en  = (state == S_WAIT) && !mem.mem_ready;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .CLK  (CLK),
        .CLRn (CLRn),
        .clr  (wait_clr),
        .en   (wait_en),
        .tc   (wait_tc)
    );

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state        <= S_IDLE;
            IPC          <= 1'b0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            ir_q         <= '0;
            ir_valid     <= 1'b0;
            halted       <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            IPC <= 1'b0;
            case (state)
                S_IDLE: if (run) state <= S_ADDR;
                S_ADDR: begin
                    mem.mem_addr <= pc_q;
                    mem.mem_rd   <= 1'b1;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem.mem_ready) begin
                        // IPC is set on the way into S_INC so it covers exactly that cycle
                        ir_q       <= mem.mem_data;
                        mem.mem_rd <= 1'b0;
                        ir_valid   <= 1'b1;
                        IPC        <= (mem.mem_data[DW-1 -: OP_W] != HALT_OP);
                        state      <= S_INC;
                    end else if (wait_tc) begin
                        bus_err    <= 1'b1;
                        halted     <= 1'b1;
                        mem.mem_rd <= 1'b0;
                        state      <= S_HALT;
                    end
                end
                S_INC: begin
                    if (op_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ex_done) begin
                        ir_valid <= 1'b0;
                        state    <= S_ADDR;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC, memory and execution-unit models plus per-scenario checks.
module tb_fetch_sequencer;
    localparam int TMAX = 128;

    logic       CLK = 1'b0;
    logic       CLRn;
    logic       run;
    logic [3:0] pc_q;
    logic       IPC;
    logic [7:0] ir_q;
    logic       ir_valid;
    logic       ex_done;
    logic       halted;
    logic       bus_err;

    logic       pc_load;
    logic [3:0] pc_init;
    logic [7:0] mem [16];
    int         mem_lat;
    int         ex_lat;
    logic       mem_en;
    int         rd_cnt;
    int         v_cnt;
    int         errors = 0;
    int         checks = 0;

    logic       tr_rd   [TMAX];
    logic       tr_ipc  [TMAX];
    logic       tr_v    [TMAX];
    logic       tr_halt [TMAX];
    logic       tr_berr [TMAX];
    logic [3:0] tr_addr [TMAX];
    logic [3:0] tr_pc   [TMAX];
    logic [7:0] tr_ir   [TMAX];

    fetch_sequencer_if #(.AW(4), .DW(8)) mif ();

    fetch_sequencer #(.AW(4), .DW(8), .HALT_OP(4'hF), .TIMEOUT(15)) dut (
        .CLK      (CLK),
        .CLRn     (CLRn),
        .run      (run),
        .pc_q     (pc_q),
        .IPC      (IPC),
        .mem      (mif),
        .ir_q     (ir_q),
        .ir_valid (ir_valid),
        .ex_done  (ex_done),
        .halted   (halted),
        .bus_err  (bus_err)
    );

    always #5 CLK = ~CLK;

    // program counter: loads on request, otherwise increments on IPC (wraps at 4 bits)
    always @(posedge CLK) begin
        if (pc_load) pc_q <= pc_init;
        else if (IPC) pc_q <= pc_q + 4'd1;
    end

    // memory answers after mem_rd has been high for mem_lat full cycles
    always @(posedge CLK or negedge CLRn) begin
        if (!CLRn) rd_cnt <= 0;
        else       rd_cnt <= mif.mem_rd ? rd_cnt + 1 : 0;
    end
    assign mif.mem_ready = mem_en && mif.mem_rd && (rd_cnt >= mem_lat);
    assign mif.mem_data  = mif.mem_ready ? mem[mif.mem_addr] : ~mem[mif.mem_addr];

    // execution unit raises done in the (ex_lat+1)-th cycle of ir_valid
    always @(posedge CLK or negedge CLRn) begin
        if (!CLRn) v_cnt <= 0;
        else       v_cnt <= ir_valid ? v_cnt + 1 : 0;
    end
    assign ex_done = ir_valid && (v_cnt >= ex_lat);

    task automatic run_trace(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge CLK);
            tr_rd[t]   = mif.mem_rd;
            tr_ipc[t]  = IPC;
            tr_v[t]    = ir_valid;
            tr_halt[t] = halted;
            tr_berr[t] = bus_err;
            tr_addr[t] = mif.mem_addr;
            tr_pc[t]   = pc_q;
            tr_ir[t]   = ir_q;
        end
    endtask

    task automatic do_reset(input logic [3:0] start);
        run     = 1'b0;
        CLRn    = 1'b0;
        pc_load = 1'b1;
        pc_init = start;
        mem_en  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        CLRn    = 1'b1;
        pc_load = 1'b0;
    endtask

    task automatic fill_mem();
        for (int a = 0; a < 16; a++)
            mem[a] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
    endtask

    function automatic int rd_rise(input int k, input int n);
        int c = 0;
        for (int t = 0; t < n; t++) begin
            if (tr_rd[t] === 1'b1 && (t == 0 || tr_rd[t-1] !== 1'b1)) begin
                if (c == k) return t;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int v_rise(input int k, input int n);
        int c = 0;
        for (int t = 0; t < n; t++) begin
            if (tr_v[t] === 1'b1 && (t == 0 || tr_v[t-1] !== 1'b1)) begin
                if (c == k) return t;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int rd_len(input int s, input int n);
        int l = 0;
        if (s < 0) return 0;
        for (int t = s; t < n; t++) begin
            if (tr_rd[t] !== 1'b1) break;
            l++;
        end
        return l;
    endfunction

    function automatic int v_len(input int s, input int n);
        int l = 0;
        if (s < 0) return 0;
        for (int t = s; t < n; t++) begin
            if (tr_v[t] !== 1'b1) break;
            l++;
        end
        return l;
    endfunction

    function automatic int count_ipc(input int from, input int to);
        int c = 0;
        for (int t = from; t < to; t++) if (tr_ipc[t] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_rd(input int n);
        int c = 0;
        for (int t = 0; t < n; t++) if (tr_rd[t] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        CLRn = 1'b1; run = 1'b0; pc_load = 1'b1; pc_init = 4'h0;
        mem_en = 1'b1; mem_lat = 0; ex_lat = 0; fill_mem();
        #3 CLRn = 1'b0;
        #1;
        checks++; if (IPC !== 1'b0)          begin errors++; $display("FAIL reset_ipc got=%b want=0", IPC); end
        checks++; if (mif.mem_rd !== 1'b0)   begin errors++; $display("FAIL reset_mem_rd got=%b want=0", mif.mem_rd); end
        checks++; if (mif.mem_addr !== 4'h0) begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mif.mem_addr); end
        checks++; if (ir_q !== 8'h00)        begin errors++; $display("FAIL reset_ir_q got=%h want=00", ir_q); end
        checks++; if (ir_valid !== 1'b0)     begin errors++; $display("FAIL reset_ir_valid got=%b want=0", ir_valid); end
        checks++; if (halted !== 1'b0)       begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
        checks++; if (bus_err !== 1'b0)      begin errors++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
    endtask

    // back-to-back fetches; expected waveform from the per-instruction cycle budget:
    // ADDR 1, WAIT lat+1, INC 1, EXEC max(1,ex_lat)
    task automatic test_stream();
        for (int trial = 0; trial < 7; trial++) begin
            int lat, exl, p, j, o, hold;
            int bad_rd, bad_ipc, bad_v, bad_addr, bad_ir;
            logic [3:0] start, e_addr;
            logic e_rd, e_ipc, e_v;
            if (trial == 0) begin
                lat = 0; exl = 0; start = 4'h0;
            end else begin
                lat = $urandom_range(0, 3); exl = $urandom_range(0, 4);
                start = 4'($urandom_range(0, 15));
            end
            fill_mem();
            mem_lat = lat; ex_lat = exl;
            do_reset(start);
            run = 1'b1;
            run_trace(60);
            hold = (exl > 1) ? exl : 1;
            p = lat + 3 + hold;
            bad_rd = 0; bad_ipc = 0; bad_v = 0; bad_addr = 0; bad_ir = 0;
            for (int t = 0; t < 60; t++) begin
                if (t == 0) begin
                    j = 0; e_rd = 1'b0; e_ipc = 1'b0; e_v = 1'b0;
                end else begin
                    j = (t - 1) / p; o = (t - 1) % p;
                    e_rd  = (o <= lat);
                    e_ipc = (o == lat + 1);
                    e_v   = (o >= lat + 1) && (o <= lat + 1 + hold);
                end
                e_addr = start + 4'(j);
                if (tr_rd[t] !== e_rd)   bad_rd++;
                if (tr_ipc[t] !== e_ipc) bad_ipc++;
                if (tr_v[t] !== e_v)     bad_v++;
                if (e_rd && tr_addr[t] !== e_addr)  bad_addr++;
                if (e_v && tr_ir[t] !== mem[e_addr]) bad_ir++;
            end
            checks++; if (bad_rd !== 0)   begin errors++; $display("FAIL stream_mem_rd trial=%0d lat=%0d exl=%0d bad_cycles=%0d want=0", trial, lat, exl, bad_rd); end
            checks++; if (bad_ipc !== 0)  begin errors++; $display("FAIL stream_ipc trial=%0d lat=%0d exl=%0d bad_cycles=%0d want=0", trial, lat, exl, bad_ipc); end
            checks++; if (bad_v !== 0)    begin errors++; $display("FAIL stream_ir_valid trial=%0d lat=%0d exl=%0d bad_cycles=%0d want=0", trial, lat, exl, bad_v); end
            checks++; if (bad_addr !== 0) begin errors++; $display("FAIL stream_mem_addr trial=%0d lat=%0d exl=%0d bad_cycles=%0d want=0", trial, lat, exl, bad_addr); end
            checks++; if (bad_ir !== 0)   begin errors++; $display("FAIL stream_ir_q trial=%0d lat=%0d exl=%0d bad_cycles=%0d want=0", trial, lat, exl, bad_ir); end
        end
    endtask

    task automatic test_latency();
        int r0, r1, ti;
        fill_mem();
        mem[2] = 8'h35;
        mem_lat = 3; ex_lat = 2;
        do_reset(4'h2);
        run = 1'b1;
        run_trace(20);
        r0 = rd_rise(0, 20);
        r1 = rd_rise(1, 20);
        if (r1 < 0) r1 = 20;
        ti = -1;
        for (int t = 19; t >= 0; t--) if (tr_ipc[t] === 1'b1 && t < r1) ti = t;
        checks++; if (rd_len(r0, 20) !== 4) begin errors++; $display("FAIL latency_rd_len got=%0d want=4", rd_len(r0, 20)); end
        checks++; if (r0 < 0 || tr_addr[r0] !== 4'h2) begin errors++; $display("FAIL latency_addr rise=%0d want addr 2", r0); end
        checks++; if (count_ipc(0, r1) !== 1) begin errors++; $display("FAIL latency_ipc_count got=%0d want=1", count_ipc(0, r1)); end
        checks++; if (ti < 0 || tr_ir[ti] !== 8'h35) begin errors++; $display("FAIL latency_ir_q ipc_at=%0d want ir 35", ti); end
        checks++; if (v_len(ti, 20) !== 3) begin errors++; $display("FAIL latency_ir_valid_len got=%0d want=3", v_len(ti, 20)); end
    endtask

    task automatic test_halt();
        int lat, p, fh;
        fill_mem();
        mem[5] = 8'hF0;
        lat = $urandom_range(0, 2);
        mem_lat = lat; ex_lat = 0;
        do_reset(4'h4);
        run = 1'b1;
        run_trace(30);
        p = lat + 4;
        fh = -1;
        for (int t = 29; t >= 0; t--) if (tr_halt[t] === 1'b1) fh = t;
        checks++; if (rd_rise(1, 30) < 0 || rd_rise(2, 30) >= 0) begin errors++; $display("FAIL halt_fetch_count second=%0d third=%0d want exactly two fetches", rd_rise(1, 30), rd_rise(2, 30)); end
        checks++; if (count_ipc(0, 30) !== 1) begin errors++; $display("FAIL halt_ipc_count got=%0d want=1", count_ipc(0, 30)); end
        checks++; if (fh !== p + lat + 3) begin errors++; $display("FAIL halt_time got=%0d want=%0d", fh, p + lat + 3); end
        checks++; if (tr_pc[29] !== 4'h5) begin errors++; $display("FAIL halt_pc got=%h want=5", tr_pc[29]); end
        checks++; if (tr_ir[29] !== 8'hF0 || tr_v[29] !== 1'b1) begin errors++; $display("FAIL halt_ir got=%h valid=%b want F0 valid 1", tr_ir[29], tr_v[29]); end
        checks++; if (tr_rd[29] !== 1'b0 || tr_berr[29] !== 1'b0) begin errors++; $display("FAIL halt_rd_berr rd=%b berr=%b want 0 0", tr_rd[29], tr_berr[29]); end
    endtask

    task automatic test_timeout();
        int fb, nb;
        fill_mem();
        mem_lat = 0; ex_lat = 0;
        do_reset(4'($urandom_range(0, 15)));
        mem_en = 1'b0;
        run = 1'b1;
        run_trace(30);
        fb = -1;
        for (int t = 29; t >= 0; t--) if (tr_berr[t] === 1'b1) fb = t;
        checks++; if (count_rd(30) !== 15) begin errors++; $display("FAIL timeout_rd_cycles got=%0d want=15", count_rd(30)); end
        checks++; if (fb !== 16) begin errors++; $display("FAIL timeout_berr_time got=%0d want=16", fb); end
        checks++; if (tr_halt[29] !== 1'b1 || tr_berr[29] !== 1'b1 || tr_rd[29] !== 1'b0) begin errors++; $display("FAIL timeout_final halted=%b berr=%b rd=%b want 1 1 0", tr_halt[29], tr_berr[29], tr_rd[29]); end
        checks++; if (count_ipc(0, 30) !== 0 || tr_v[29] !== 1'b0) begin errors++; $display("FAIL timeout_no_instr ipc=%0d valid=%b want 0 0", count_ipc(0, 30), tr_v[29]); end

        // ready arriving in the last allowed WAIT cycle still wins
        fill_mem();
        mem_lat = 14; ex_lat = 0;
        do_reset(4'h3);
        run = 1'b1;
        run_trace(25);
        nb = 0;
        for (int t = 0; t < 25; t++) if (tr_berr[t] === 1'b1) nb++;
        checks++; if (rd_len(1, 25) !== 15) begin errors++; $display("FAIL edge_rd_len got=%0d want=15", rd_len(1, 25)); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL edge_no_berr got=%0d want=0", nb); end
        checks++; if (tr_ipc[16] !== 1'b1 || tr_ir[16] !== mem[3]) begin errors++; $display("FAIL edge_fetch ipc=%b ir=%h want 1 %h", tr_ipc[16], tr_ir[16], mem[3]); end
    endtask

    task automatic test_reset_mid();
        fill_mem();
        mem_lat = 10; ex_lat = 0;
        do_reset(4'h6);
        run = 1'b1;
        repeat (4) @(negedge CLK);
        checks++; if (mif.mem_rd !== 1'b1) begin errors++; $display("FAIL midwait_pre rd=%b want=1", mif.mem_rd); end
        #2 CLRn = 1'b0;
        #1;
        checks++; if (mif.mem_rd !== 1'b0 || ir_valid !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL midwait_async rd=%b valid=%b berr=%b want 0 0 0", mif.mem_rd, ir_valid, bus_err); end
        @(negedge CLK);
        CLRn = 1'b1; run = 1'b0;
        run_trace(5);
        checks++; if (count_rd(5) !== 0) begin errors++; $display("FAIL midwait_idle rd_cycles=%0d want=0", count_rd(5)); end
        run = 1'b1;
        run_trace(4);
        checks++; if (tr_rd[1] !== 1'b1 || tr_addr[1] !== 4'h6) begin errors++; $display("FAIL midwait_restart rd=%b addr=%h want 1 6", tr_rd[1], tr_addr[1]); end

        mem_lat = 0; ex_lat = 20;
        do_reset(4'h1);
        run = 1'b1;
        run_trace(6);
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL midexec_pre valid=%b want=1", ir_valid); end
        #2 CLRn = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || ir_q !== 8'h00) begin errors++; $display("FAIL midexec_async valid=%b ir=%h want 0 00", ir_valid, ir_q); end

        mem_lat = 0; ex_lat = 0;
        do_reset(4'h9);
        mem_en = 1'b0;
        run = 1'b1;
        run_trace(20);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL midhalt_pre berr=%b want=1", bus_err); end
        #2 CLRn = 1'b0;
        #1;
        checks++; if (bus_err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midhalt_async berr=%b halted=%b want 0 0", bus_err, halted); end
        @(negedge CLK);
        CLRn = 1'b1; run = 1'b0;
    endtask

    task automatic test_wrap();
        int r0, r1, v0, v1;
        fill_mem();
        mem_lat = 0; ex_lat = 4;
        do_reset(4'hF);
        run = 1'b1;
        run_trace(20);
        r0 = rd_rise(0, 20);
        r1 = rd_rise(1, 20);
        v0 = v_rise(0, 20);
        v1 = v_rise(1, 20);
        checks++; if (r0 < 0 || tr_addr[r0] !== 4'hF) begin errors++; $display("FAIL wrap_addr0 rise=%0d want addr F", r0); end
        checks++; if (r1 < 0 || tr_addr[r1] !== 4'h0) begin errors++; $display("FAIL wrap_addr1 rise=%0d want addr 0", r1); end
        checks++; if (v_len(v0, 20) !== 5 || v_len(v1, 20) !== 5) begin errors++; $display("FAIL wrap_valid_len got=%0d,%0d want 5,5", v_len(v0, 20), v_len(v1, 20)); end
        checks++; if (v0 < 0 || v1 < 0 || tr_ir[v0] !== mem[15] || tr_ir[v1] !== mem[0]) begin errors++; $display("FAIL wrap_ir starts=%0d,%0d want %h then %h", v0, v1, mem[15], mem[0]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_halt();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
